// File: rtl/ysyx_041514_if_responder_if.sv
// Fetch-port and memory read-channel bundle for the instruction-fetch responder.
interface ysyx_041514_if_responder_if #(
    parameter int unsigned XLEN = 64
);
    // Fetch side
    logic [XLEN-1:0] inst_addr_i;
    logic            if_rdata_valid_o;
    logic [XLEN-1:0] if_rdata_o;
    logic            if_access_fault_o;
    // Memory read channel
    logic            ar_valid_o;
    logic            ar_ready_i;
    logic [XLEN-1:0] ar_addr_o;
    logic            r_valid_i;
    logic            r_ready_o;
    logic [XLEN-1:0] r_data_i;
    logic [1:0]      r_resp_i;

    // Responder side: issues reads, serves the fetch stage
    modport master (
        input  inst_addr_i,
        output if_rdata_valid_o,
        output if_rdata_o,
        output if_access_fault_o,
        output ar_valid_o,
        input  ar_ready_i,
        output ar_addr_o,
        input  r_valid_i,
        output r_ready_o,
        input  r_data_i,
        input  r_resp_i
    );

    // Environment side: pc_reg/fetch plus the memory read master
    modport slave (
        output inst_addr_i,
        input  if_rdata_valid_o,
        input  if_rdata_o,
        input  if_access_fault_o,
        input  ar_valid_o,
        output ar_ready_i,
        input  ar_addr_o,
        output r_valid_i,
        input  r_ready_o,
        output r_data_i,
        output r_resp_i
    );
endinterface

// File: rtl/ysyx_041514_if_responder.sv
// Instruction-fetch responder: one outstanding read per PC, holds the fetched
// word until the PC moves. Stale beats after a redirect are drained and dropped.
module ysyx_041514_if_responder #(
    parameter int unsigned XLEN = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_041514_if_responder_if.master  bus
);
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HIT
    } state_e;

    state_e            state;
    logic [XLEN-1:0]   req_addr;
    logic [WORD_W-1:0] data_buf;
    logic              fault_buf;
    logic              ar_valid_q;
    logic              r_ready_q;
    logic              addr_match;
    logic              in_hit;
    logic              rdata_valid;

    assign addr_match = (bus.inst_addr_i == req_addr);
    assign in_hit     = (state == S_HIT);

    // Fetch FSM: request, drain response, hold word until PC changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_addr   <= '0;
            data_buf   <= '0;
            fault_buf  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_addr   <= bus.inst_addr_i;
                    ar_valid_q <= 1'b1;
                    state      <= S_REQ;
                end
                S_REQ: begin
                    // Address phase is never withdrawn once raised
                    if (ar_valid_q && bus.ar_ready_i) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.r_valid_i) begin
                        r_ready_q <= 1'b0;
                        if (addr_match) begin
                            data_buf  <= req_addr[2] ? bus.r_data_i[63:32]
                                                     : bus.r_data_i[31:0];
                            fault_buf <= (bus.r_resp_i != 2'b00);
                            state     <= S_HIT;
                        end else begin
                            // PC moved while in flight: drop beat, refetch
                            req_addr   <= bus.inst_addr_i;
                            ar_valid_q <= 1'b1;
                            state      <= S_REQ;
                        end
                    end
                end
                S_HIT: begin
                    // PC advance consumes the held instruction
                    if (!addr_match) begin
                        req_addr   <= bus.inst_addr_i;
                        ar_valid_q <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Valid drops the moment the PC no longer matches the held word
    assign rdata_valid           = in_hit && addr_match;
    assign bus.if_rdata_valid_o  = rdata_valid;
    assign bus.if_rdata_o        = in_hit ? XLEN'(data_buf) : '0;
    assign bus.if_access_fault_o = fault_buf && rdata_valid;

    // Read channel driven straight from registers
    assign bus.ar_valid_o = ar_valid_q;
    assign bus.ar_addr_o  = {req_addr[XLEN-1:3], 3'b000};
    assign bus.r_ready_o  = r_ready_q;
endmodule

// File: tb/tb_ysyx_041514_if_responder.sv
// Directed bench for the instruction-fetch responder.
module tb_ysyx_041514_if_responder;
    localparam int unsigned XLEN = 64;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ysyx_041514_if_responder_if #(.XLEN(XLEN)) bus ();

    ysyx_041514_if_responder #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; sample/drive point is 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, " valid"}, 64'(bus.if_rdata_valid_o), 64'd0);
        check({tag, " rdata"}, bus.if_rdata_o, 64'd0);
        check({tag, " fault"}, 64'(bus.if_access_fault_o), 64'd0);
        check({tag, " ar_valid"}, 64'(bus.ar_valid_o), 64'd0);
        check({tag, " r_ready"}, 64'(bus.r_ready_o), 64'd0);
    endtask

    // One beat on the read data channel for a single cycle
    task automatic beat(input logic [63:0] data, input logic [1:0] resp);
        bus.r_valid_i = 1'b1;
        bus.r_data_i  = data;
        bus.r_resp_i  = resp;
        step();
        bus.r_valid_i = 1'b0;
        bus.r_data_i  = '0;
        bus.r_resp_i  = 2'b00;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst               = 1'b1;
        bus.inst_addr_i   = '0;
        bus.ar_ready_i    = 1'b0;
        bus.r_valid_i     = 1'b0;
        bus.r_data_i      = '0;
        bus.r_resp_i      = 2'b00;
        step();
        step();
        check_all_low("reset");

        // First fetch: lower word of the doubleword
        bus.inst_addr_i = 64'h8000_0000;
        bus.ar_ready_i  = 1'b1;
        rst             = 1'b0;
        step();
        check("f0 ar_valid", 64'(bus.ar_valid_o), 64'd1);
        check("f0 ar_addr", bus.ar_addr_o, 64'h8000_0000);
        check("f0 valid in REQ", 64'(bus.if_rdata_valid_o), 64'd0);
        step();
        check("f0 ar_valid after hs", 64'(bus.ar_valid_o), 64'd0);
        check("f0 r_ready", 64'(bus.r_ready_o), 64'd1);
        check("f0 valid in WAIT", 64'(bus.if_rdata_valid_o), 64'd0);
        beat(64'h0000_0013_0010_0093, 2'b00);
        check("f0 valid", 64'(bus.if_rdata_valid_o), 64'd1);
        check("f0 rdata", bus.if_rdata_o, 64'h0000_0000_0010_0093);
        check("f0 fault", 64'(bus.if_access_fault_o), 64'd0);
        check("f0 r_ready off", 64'(bus.r_ready_o), 64'd0);

        // PC+4: upper word, valid exactly 3 edges after the change
        bus.inst_addr_i = 64'h8000_0004;
        #1;
        check("f1 valid drops on pc change", 64'(bus.if_rdata_valid_o), 64'd0);
        step();
        check("f1 ar_addr aligned", bus.ar_addr_o, 64'h8000_0000);
        check("f1 valid edge1", 64'(bus.if_rdata_valid_o), 64'd0);
        step();
        check("f1 valid edge2", 64'(bus.if_rdata_valid_o), 64'd0);
        beat(64'h0000_0013_0010_0093, 2'b00);
        check("f1 valid edge3", 64'(bus.if_rdata_valid_o), 64'd1);
        check("f1 rdata", bus.if_rdata_o, 64'h0000_0000_0000_0013);

        // Back-pressure on ar while the PC redirects
        bus.ar_ready_i  = 1'b0;
        bus.inst_addr_i = 64'h8000_0008;
        step();
        check("bp ar_addr", bus.ar_addr_o, 64'h8000_0008);
        bus.inst_addr_i = 64'h8000_0100;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("bp%0d ar_valid", i), 64'(bus.ar_valid_o), 64'd1);
            check($sformatf("bp%0d ar_addr stable", i), bus.ar_addr_o, 64'h8000_0008);
            check($sformatf("bp%0d valid", i), 64'(bus.if_rdata_valid_o), 64'd0);
        end
        bus.ar_ready_i = 1'b1;
        step();
        check("bp r_ready", 64'(bus.r_ready_o), 64'd1);
        beat(64'hAAAA_AAAA_BBBB_BBBB, 2'b00);
        check("bp stale dropped valid", 64'(bus.if_rdata_valid_o), 64'd0);
        check("bp reissue ar_valid", 64'(bus.ar_valid_o), 64'd1);
        check("bp reissue ar_addr", bus.ar_addr_o, 64'h8000_0100);
        step();
        check("bp wait valid", 64'(bus.if_rdata_valid_o), 64'd0);
        beat(64'h1111_1111_2222_2222, 2'b00);
        check("bp valid", 64'(bus.if_rdata_valid_o), 64'd1);
        check("bp rdata", bus.if_rdata_o, 64'h0000_0000_2222_2222);

        // Bus error, then clean fetch
        bus.inst_addr_i = 64'h8000_0104;
        step();
        step();
        beat(64'h3333_3333_4444_4444, 2'b10);
        check("err valid", 64'(bus.if_rdata_valid_o), 64'd1);
        check("err fault", 64'(bus.if_access_fault_o), 64'd1);
        check("err rdata", bus.if_rdata_o, 64'h0000_0000_3333_3333);
        bus.inst_addr_i = 64'h8000_0108;
        #1;
        check("err fault masked by valid", 64'(bus.if_access_fault_o), 64'd0);
        step();
        step();
        beat(64'h5555_5555_0000_0073, 2'b00);
        check("ok valid", 64'(bus.if_rdata_valid_o), 64'd1);
        check("ok fault", 64'(bus.if_access_fault_o), 64'd0);
        check("ok rdata", bus.if_rdata_o, 64'h0000_0000_0000_0073);

        // PC held: no new request, word held
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold%0d ar_valid", i), 64'(bus.ar_valid_o), 64'd0);
            check($sformatf("hold%0d valid", i), 64'(bus.if_rdata_valid_o), 64'd1);
        end
        check("hold rdata", bus.if_rdata_o, 64'h0000_0000_0000_0073);

        // Asynchronous reset in WAIT, then refetch for the current PC
        bus.inst_addr_i = 64'h8000_0200;
        step();
        step();
        check("rst pre r_ready", 64'(bus.r_ready_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_low("async rst");
        step();
        rst = 1'b0;
        step();
        check("post rst ar_valid", 64'(bus.ar_valid_o), 64'd1);
        check("post rst ar_addr", bus.ar_addr_o, 64'h8000_0200);
        step();
        beat(64'h6666_6666_7777_7777, 2'b00);
        check("post rst valid", 64'(bus.if_rdata_valid_o), 64'd1);
        check("post rst rdata", bus.if_rdata_o, 64'h0000_0000_7777_7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
